// File: rtl/stream_fifo_pkg.sv
// rtl/stream_fifo_pkg.sv - shared constants and types for the stream FIFO
package stream_fifo_pkg;

   // Pointer width: index bits plus one wrap bit that tells full from empty.
   function automatic int ptr_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

   typedef struct packed {
      logic almost_full;
      logic almost_empty;
   } flags_t;

endpackage

// File: rtl/stream_fifo_mem.sv
// rtl/stream_fifo_mem.sv - FIFO storage: one write port, one combinational read port
module stream_fifo_mem #(
   parameter  int DATA_W = 32,
   parameter  int DEPTH  = 8,
   localparam int AW     = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [AW-1:0]     raddr,
   output logic [DATA_W-1:0] rdata
);

   // Deliberately unreset: contents are qualified by the pointers.
   logic [DATA_W-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         r_mem[waddr] <= wdata;
      end
   end

   assign rdata = r_mem[raddr];

endmodule

// File: rtl/stream_fifo.sv
// rtl/stream_fifo.sv - valid/ready FIFO with first-word-fall-through output,
// occupancy count, watermarks and synchronous flush
module stream_fifo
   import stream_fifo_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int DEPTH     = 8,
   parameter int AF_THRESH = DEPTH - 2,
   parameter int AE_THRESH = 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      flush,
   input  logic                      s_valid,
   output logic                      s_ready,
   input  logic [DATA_W-1:0]         s_data,
   output logic                      m_valid,
   input  logic                      m_ready,
   output logic [DATA_W-1:0]         m_data,
   output logic [$clog2(DEPTH):0]    count,
   output logic                      almost_full,
   output logic                      almost_empty
);

   localparam int AW    = $clog2(DEPTH);
   localparam int PTR_W = ptr_w(DEPTH);

   typedef logic [PTR_W-1:0] ptr_t;

   localparam ptr_t ONE     = ptr_t'(1);
   localparam ptr_t AF_C    = ptr_t'(AF_THRESH);
   localparam ptr_t AE_C    = ptr_t'(AE_THRESH);
   localparam ptr_t DEPTH_C = ptr_t'(DEPTH);

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("stream_fifo: DEPTH must be a power of two and at least 2");
   end
   if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
      $error("stream_fifo: AF_THRESH out of range 1..DEPTH");
   end
   if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
      $error("stream_fifo: AE_THRESH out of range 0..DEPTH-1");
   end

   ptr_t   r_wr_ptr;
   ptr_t   r_rd_ptr;
   ptr_t   r_count;
   logic   w_empty;
   logic   w_full;
   logic   w_push;
   logic   w_pop;
   flags_t w_flags;

   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                    (r_wr_ptr[AW] != r_rd_ptr[AW]);

   // s_ready comes from flops only, so a full FIFO refuses a push even while popping.
   assign s_ready = !w_full;
   assign m_valid = !w_empty;
   assign w_push  = s_valid && !w_full;
   assign w_pop   = m_ready && !w_empty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + ONE;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + ONE;
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + ONE;
         end else if (w_pop && !w_push) begin
            r_count <= r_count - ONE;
         end
      end
   end

   stream_fifo_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_mem (
      .clk   (clk),
      .we    (w_push && !flush),
      .waddr (r_wr_ptr[AW-1:0]),
      .wdata (s_data),
      .raddr (r_rd_ptr[AW-1:0]),
      .rdata (m_data)
   );

   assign w_flags.almost_full  = (r_count >= AF_C);
   assign w_flags.almost_empty = (r_count <= AE_C);
   assign almost_full          = w_flags.almost_full;
   assign almost_empty         = w_flags.almost_empty;
   assign count                = r_count;

`ifndef SYNTHESIS
   a_src_hold: assert property (@(posedge clk) disable iff (!rst_n)
      (s_valid && !s_ready) |=> (s_valid && $stable(s_data)));
   a_count_max: assert property (@(posedge clk) disable iff (!rst_n)
      r_count <= DEPTH_C);
   a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
      w_push |-> !w_full);
   a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst_n)
      w_pop |-> !w_empty);
`endif

endmodule

// File: doc/stream_fifo.md
Name: stream_fifo

Overview:
- Parametrised synchronous valid/ready FIFO with first-word-fall-through output.
- Sits between a producer using an output-qualified stream port and a consumer using an input-qualified stream port. It decouples their timing.
- Generalises a fixed single-register hand-off in three ways:
  - data width and depth are parametrised;
  - occupancy count and almost-full/almost-empty watermarks are provided;
  - a synchronous flush is provided.

Parameters:
- DATA_W, 32, payload width in bits (≥1).
- DEPTH, 8, number of entries. Must be a power of two and ≥2; elaboration error otherwise.
- AF_THRESH, DEPTH-2, almost_full asserts when count ≥ AF_THRESH. Range 1..DEPTH.
- AE_THRESH, 1, almost_empty asserts when count ≤ AE_THRESH. Range 0..DEPTH-1.

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous reset, active-low
- flush  input  1  synchronous clear of contents
- s_valid  input  1  producer has data
- s_ready  output  1  FIFO can accept
- s_data  input  DATA_W  write payload
- m_valid  output  1  head entry valid
- m_ready  input  1  consumer accepts head
- m_data  output  DATA_W  head payload
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- almost_full  output  1  watermark flag
- almost_empty  output  1  watermark flag

Behaviour:
- Reset (rst_n low, asynchronous):
  - Pointers and count go to 0.
  - Outputs: m_valid=0, s_ready=1, count=0, almost_full=0 (AF_THRESH≥1), almost_empty=1.
  - Storage array is not reset. m_data is don't-care while m_valid=0.
- Reset mid-operation: contents are discarded immediately. No transfer completes in the cycle rst_n is sampled low.
- Pointers: wr_ptr and rd_ptr are $clog2(DEPTH)+1 bits wide, with an MSB wrap bit.
  - empty when the pointers are equal.
  - full when the low bits are equal and the MSBs differ.
  - The index wraps naturally DEPTH-1 → 0.
- Push = s_valid & s_ready. Pop = m_valid & m_ready. Both are evaluated on the rising edge.
- s_ready = !full. It depends only on flops; there is no combinational path from m_ready.
  - A full FIFO therefore refuses a push even when a pop happens in the same cycle.
- m_valid = !empty. m_data = mem[rd_ptr].
  - Read is combinational from the storage array (FWFT).
  - Latency: data pushed at edge N is visible on m_data/m_valid after edge N, i.e. one cycle.
  - No same-cycle bypass when empty.
- Stability: while m_valid=1 and m_ready=0, m_data and m_valid hold stable.
- Count update:
  - push only: +1
  - pop only: −1
  - push and pop: unchanged, both pointers advance
  - neither: unchanged
- Watermarks:
  - almost_full = (count ≥ AF_THRESH); almost_empty = (count ≤ AE_THRESH).
  - Both derive from registered count; no extra latency.
- flush:
  - Takes priority over push and pop in the same cycle.
  - Both pointers and count go to 0 at that edge. The concurrent push is dropped and the concurrent pop is void.
  - s_ready stays combinational (!full), so during a flush cycle it may read 1 while the push is discarded. The producer must not rely on acceptance during flush.
- Protocol checks (simulation-only assertions):
  - s_valid held with s_data stable until s_ready.
  - count never exceeds DEPTH.
  - No push when full, no pop when empty.

Decomposition:
- Package stream_fifo_pkg holds:
  - function for the pointer-width constant;
  - typedef ptr_t (logic [$clog2(DEPTH):0]) as a parametrised-class or localparam pattern;
  - typedef of the flag struct {almost_full, almost_empty}.
- Sub-module stream_fifo_mem:
  - DEPTH×DATA_W register array;
  - one write port (we, waddr, wdata), one combinational read port (raddr, rdata);
  - no reset.
- stream_fifo itself holds the pointers, count, flags and handshake logic.

Test Plan:
- Reset then idle:
  - assert rst_n=0 mid-burst with count=5 → next sample count=0, m_valid=0, s_ready=1, almost_empty=1.
- Fill to full (DEPTH=8, DATA_W=32):
  - push 0x00..0x07 back-to-back with m_ready=0 → count steps 1..8; almost_full rises when count=6; s_ready=0 at count=8.
  - a 9th s_valid is not accepted.
- Drain in order:
  - from full, m_ready=1 → m_data reads 0x00..0x07 over 8 cycles; m_valid falls after the last; count=0.
- Simultaneous push/pop at mid-level (count=4):
  - s_valid=m_ready=1 for 20 cycles → count stays 4; outputs match input order delayed by 4 entries.
  - pointers wrap at least twice.
- Full with pop:
  - count=8, s_valid=1, m_ready=1 → pop occurs, push refused; next cycle count=7, s_ready=1.
- Flush priority:
  - count=3, flush=1 with s_valid=1 and m_ready=1 → next cycle count=0, m_valid=0; the pushed word never appears at m_data.
- Backpressure stability:
  - m_ready toggled randomly 1/3 duty with random s_valid → scoreboard shows no loss, reorder or duplication.
  - m_data is stable whenever m_valid & !m_ready.
